controle_multiciclo: RTL and testbench
======================================

Name: controle_multiciclo

Overview:
Control unit that sequences the multicycle processor datapath (register file R0..R7, A/G registers, adder/subtractor, shared 16-bit bus).
- Captures a 9-bit instruction from DIN when Run is high.
- Steps through T0..T3 and drives one-hot register enables, bus-source selects and ALU control.
- Signals Done in the last step of each instruction.
- Sits between the DIN/Run interface and the datapath muxes; replaces ad-hoc control inside the processor top.

Parameters:
DATA_W, 16, width of DIN and the bus
IR_W, 9, instruction width; fields {opcode[8:6], Rx[5:3], Ry[2:0]}

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
DIN  input  DATA_W  instruction word (bits [8:0]) in T0; immediate data in T1 of mvi
Run  input  1  start request, sampled only in T0
IRin  output  1  instruction capture strobe (mirrors internal IR load)
Rin  output  8  one-hot register write enable, bit i = Ri
Rout  output  8  one-hot register bus-drive select, bit i = Ri
DINout  output  1  DIN drives bus
Gout  output  1  G drives bus
Ain  output  1  load A from bus
Gin  output  1  load G from ALU
AluOp  output  2  00 add, 01 sub, 10 and, 11 or
Done  output  1  last step of current instruction
Illegal  output  1  undefined opcode, pulsed in T1
Tstep  output  2  current time step, 0..3

Behaviour:
- Reset high: Tstep=0 and IR=0 immediately, independent of Clock. All outputs are 0, including mid-instruction.
- Control outputs are combinational from Tstep, IR, Run and Reset. Only Tstep and IR are registered.
- At most one of Rout[*], DINout, Gout is high in any cycle. All are 0 in T0.
- T0: IRin = Run.
  - Rising edge with Run=1: IR <= DIN[8:0], Tstep <= 1.
  - Run=0: remain in T0, IR unchanged.
  - Run is ignored in T1..T3.
- Opcode 000, mv Rx,Ry: T1 Rout[Ry]=1, Rin[Rx]=1, Done=1. Then T0.
- Opcode 001, mvi Rx,#D: T1 DINout=1, Rin[Rx]=1, Done=1. Then T0. Ry field ignored.
- Opcode 010 add / 011 sub, Rx <= Rx op Ry:
  - T1: Rout[Rx]=1, Ain=1.
  - T2: Rout[Ry]=1, Gin=1, AluOp=00 (add) or 01 (sub).
  - T3: Gout=1, Rin[Rx]=1, Done=1, AluOp held at its T2 value. Then T0.
- Rx==Ry is legal. add R3,R3 doubles R3; the sequence is unchanged.
- Undefined opcode: T1 Done=1, Illegal=1, all enables 0. Then T0. Datapath state is untouched.
- AluOp is 00 whenever Gin=0 and not in T3.
- Done is high for exactly one cycle per instruction. Back-to-back instructions need Run high in the T0 following Done. Minimum issue interval: 2 cycles (mv/mvi), 4 cycles (add/sub).
- Tstep wraps 3 -> 0 only via Done. Encoding 3 is reached only by add/sub (and/or with the macro).

Optional Feature:
CTRL_LOGIC_OPS_EN
- Defined: opcode 100 = and, 101 = or. Same T1..T3 sequence as add, with AluOp=10 / 11 in T2 and T3. Opcodes 110 and 111 remain illegal.
- Undefined: opcodes 100..111 are illegal. AluOp never takes values 10 or 11.

Test Plan:
- mv R0,R1: DIN=0x0001, Run=1 for one cycle in T0 -> IRin=1 in T0; next cycle Tstep=1, Rout=8'b00000010, Rin=8'b00000001, Done=1; following cycle Tstep=0, all outputs 0.
- mvi R2,#5: DIN=0x0050 with Run, then DIN=0x0005 -> T1 DINout=1, Rin=8'b00000100, Done=1, Rout=0.
- add R3,R4 (DIN=0x009C), then sub R3,R4 (DIN=0x00DC) -> add: T1 Rout=8'b00001000 with Ain; T2 Rout=8'b00010000, Gin, AluOp=00; T3 Gout, Rin=8'b00001000, Done. sub: same sequence with AluOp=01 in T2 and T3.
- Run held 0 for 5 cycles in T0 -> Tstep stays 0, IRin=0, Done=0. Run pulsed high during T2 of an add -> no effect on sequence.
- Reset asserted between clock edges during T2 of add R3,R4 -> Tstep=0 and all outputs 0 before the next edge. After release, Run=1 with DIN=0x0001 executes mv normally.
- DIN=0x0188 (opcode 110) -> T1 Illegal=1, Done=1, Rin=0, Rout=0. With CTRL_LOGIC_OPS_EN, DIN=0x0108 (and R1,R0) -> T2 AluOp=10, T3 Rin=8'b00000010, Done=1.

Source files
------------

// File: rtl/controle_multiciclo.sv
// rtl/controle_multiciclo.sv - multicycle datapath control unit (T0..T3 sequencer)
// Optional macro CTRL_LOGIC_OPS_EN: opcodes 100/101 become and/or.
module controle_multiciclo #(
  parameter int DATA_W = 16,
  parameter int IR_W   = 9
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] DIN,
  input  logic              Run,
  output logic              IRin,
  output logic [7:0]        Rin,
  output logic [7:0]        Rout,
  output logic              DINout,
  output logic              Gout,
  output logic              Ain,
  output logic              Gin,
  output logic [1:0]        AluOp,
  output logic              Done,
  output logic              Illegal,
  output logic [1:0]        Tstep
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
`ifdef CTRL_LOGIC_OPS_EN
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
`endif

  tstep_t          state, state_nxt;
  logic [IR_W-1:0] ir;
  logic [2:0]      opcode, rx, ry;
  logic [7:0]      rx_oh, ry_oh;
  logic            is_alu;
  logic [1:0]      alu_code;
  logic            din_unused;

  // Only the low IR_W bits of DIN ever carry an instruction.
  assign din_unused = ^DIN[DATA_W-1:IR_W];

  assign opcode = ir[8:6];
  assign rx     = ir[5:3];
  assign ry     = ir[2:0];
  assign rx_oh  = 8'b1 << rx;
  assign ry_oh  = 8'b1 << ry;
  assign Tstep  = state;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == T0 && Run) ir <= DIN[IR_W-1:0];
    end
  end

  always_comb begin
    is_alu   = 1'b0;
    alu_code = 2'b00;
    case (opcode)
      OP_ADD: is_alu = 1'b1;
      OP_SUB: begin is_alu = 1'b1; alu_code = 2'b01; end
`ifdef CTRL_LOGIC_OPS_EN
      OP_AND: begin is_alu = 1'b1; alu_code = 2'b10; end
      OP_OR:  begin is_alu = 1'b1; alu_code = 2'b11; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    IRin      = 1'b0;
    Rin       = 8'b0;
    Rout      = 8'b0;
    DINout    = 1'b0;
    Gout      = 1'b0;
    Ain       = 1'b0;
    Gin       = 1'b0;
    AluOp     = 2'b00;
    Done      = 1'b0;
    Illegal   = 1'b0;
    case (state)
      T0: begin
        IRin = Run;
        if (Run) state_nxt = T1;
      end
      T1: begin
        if (opcode == OP_MV) begin
          Rout = ry_oh;
          Rin  = rx_oh;
          Done = 1'b1;
        end else if (opcode == OP_MVI) begin
          DINout = 1'b1;
          Rin    = rx_oh;
          Done   = 1'b1;
        end else if (is_alu) begin
          Rout = rx_oh;
          Ain  = 1'b1;
        end else begin
          Done    = 1'b1;
          Illegal = 1'b1;
        end
        state_nxt = Done ? T0 : T2;
      end
      T2: begin
        if (is_alu) begin
          Rout      = ry_oh;
          Gin       = 1'b1;
          AluOp     = alu_code;
          state_nxt = T3;
        end else begin
          state_nxt = T0;
        end
      end
      T3: begin
        Gout      = 1'b1;
        Rin       = rx_oh;
        Done      = 1'b1;
        AluOp     = alu_code;
        state_nxt = T0;
      end
      default: state_nxt = T0;
    endcase
    // Reset silences every control line at once, even between clock edges.
    if (Reset) begin
      IRin    = 1'b0;
      Rin     = 8'b0;
      Rout    = 8'b0;
      DINout  = 1'b0;
      Gout    = 1'b0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      AluOp   = 2'b00;
      Done    = 1'b0;
      Illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// tb/tb_controle_multiciclo.sv - scoreboard bench for controle_multiciclo
module tb_controle_multiciclo;

  typedef struct {
    logic [15:0] din;
    logic        run;
    logic [26:0] exp;
  } stim_t;

  logic        Clock, Reset, Run;
  logic [15:0] DIN;
  logic        IRin, DINout, Gout, Ain, Gin, Done, Illegal;
  logic [7:0]  Rin, Rout;
  logic [1:0]  AluOp, Tstep;
  logic [26:0] obs;
  logic [26:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  controle_multiciclo #(.DATA_W(16), .IR_W(9)) dut (
    .Clock(Clock), .Reset(Reset), .DIN(DIN), .Run(Run),
    .IRin(IRin), .Rin(Rin), .Rout(Rout), .DINout(DINout), .Gout(Gout),
    .Ain(Ain), .Gin(Gin), .AluOp(AluOp), .Done(Done), .Illegal(Illegal),
    .Tstep(Tstep)
  );

  assign obs = {Tstep, IRin, Rin, Rout, DINout, Gout, Ain, Gin, AluOp, Done, Illegal};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  function automatic logic [26:0] ev(logic [1:0] ts, logic irin, logic [7:0] rin,
                                     logic [7:0] rout, logic dino, logic go, logic ai,
                                     logic gi, logic [1:0] op, logic dn, logic il);
    return {ts, irin, rin, rout, dino, go, ai, gi, op, dn, il};
  endfunction

  function automatic stim_t mk(logic [15:0] din, logic run, logic [26:0] e);
    stim_t s;
    s.din = din;
    s.run = run;
    s.exp = e;
    return s;
  endfunction

  localparam logic [26:0] IDLE = 27'd0;
  localparam logic [26:0] T0GO = {2'd0, 1'b1, 24'd0};

  // Drive one cycle's inputs just after the edge and queue what the DUT must show.
  task automatic drive(input stim_t s);
    @(posedge Clock);
    #1;
    DIN = s.din;
    Run = s.run;
    exp_q.push_back(s.exp);
  endtask

  task automatic test_reset();
    logic [26:0] e;
    Reset = 1'b1; DIN = 16'h0001; Run = 1'b1;
    exp_q.push_back(IDLE);
    @(negedge Clock);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset_hold got=%h want=%h", obs, e); end
    @(posedge Clock); #1;
    exp_q.push_back(IDLE);
    @(negedge Clock);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset_edge got=%h want=%h", obs, e); end
    Reset = 1'b0; Run = 1'b0;
  endtask

  task automatic test_mv_mvi();
    stim_t t[$];
    logic [26:0] e;
    t.push_back(mk(16'h0001, 1'b1, T0GO));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd1, 0, 8'h01, 8'h02, 0, 0, 0, 0, 2'b00, 1, 0)));
    t.push_back(mk(16'h0000, 1'b0, IDLE));
    t.push_back(mk(16'h0050, 1'b1, T0GO));
    t.push_back(mk(16'h0005, 1'b0, ev(2'd1, 0, 8'h04, 8'h00, 1, 0, 0, 0, 2'b00, 1, 0)));
    t.push_back(mk(16'h0000, 1'b0, IDLE));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge Clock);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL mv_mvi[%0d] got=%h want=%h", i, obs, e); end
    end
  endtask

  task automatic test_add_sub();
    stim_t t[$];
    logic [26:0] e;
    t.push_back(mk(16'h009C, 1'b1, T0GO));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd1, 0, 8'h00, 8'h08, 0, 0, 1, 0, 2'b00, 0, 0)));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd2, 0, 8'h00, 8'h10, 0, 0, 0, 1, 2'b00, 0, 0)));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd3, 0, 8'h08, 8'h00, 0, 1, 0, 0, 2'b00, 1, 0)));
    t.push_back(mk(16'h00DC, 1'b1, T0GO));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd1, 0, 8'h00, 8'h08, 0, 0, 1, 0, 2'b00, 0, 0)));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd2, 0, 8'h00, 8'h10, 0, 0, 0, 1, 2'b01, 0, 0)));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd3, 0, 8'h08, 8'h00, 0, 1, 0, 0, 2'b01, 1, 0)));
    t.push_back(mk(16'h009B, 1'b1, T0GO));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd1, 0, 8'h00, 8'h08, 0, 0, 1, 0, 2'b00, 0, 0)));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd2, 0, 8'h00, 8'h08, 0, 0, 0, 1, 2'b00, 0, 0)));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd3, 0, 8'h08, 8'h00, 0, 1, 0, 0, 2'b00, 1, 0)));
    t.push_back(mk(16'h0000, 1'b0, IDLE));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge Clock);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL add_sub[%0d] got=%h want=%h", i, obs, e); end
    end
  endtask

  task automatic test_run_ignore();
    stim_t t[$];
    logic [26:0] e;
    for (int k = 0; k < 5; k++) t.push_back(mk(16'h0001, 1'b0, IDLE));
    t.push_back(mk(16'h009C, 1'b1, T0GO));
    t.push_back(mk(16'h01C8, 1'b0, ev(2'd1, 0, 8'h00, 8'h08, 0, 0, 1, 0, 2'b00, 0, 0)));
    t.push_back(mk(16'h01C8, 1'b1, ev(2'd2, 0, 8'h00, 8'h10, 0, 0, 0, 1, 2'b00, 0, 0)));
    t.push_back(mk(16'h01C8, 1'b1, ev(2'd3, 0, 8'h08, 8'h00, 0, 1, 0, 0, 2'b00, 1, 0)));
    t.push_back(mk(16'h0000, 1'b0, IDLE));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge Clock);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL run_ignore[%0d] got=%h want=%h", i, obs, e); end
    end
  endtask

  task automatic test_reset_mid();
    stim_t t[$];
    stim_t r[$];
    logic [26:0] e;
    t.push_back(mk(16'h009C, 1'b1, T0GO));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd1, 0, 8'h00, 8'h08, 0, 0, 1, 0, 2'b00, 0, 0)));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd2, 0, 8'h00, 8'h10, 0, 0, 0, 1, 2'b00, 0, 0)));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge Clock);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL reset_mid_pre[%0d] got=%h want=%h", i, obs, e); end
    end
    Reset = 1'b1;
    exp_q.push_back(IDLE);
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset_async got=%h want=%h", obs, e); end
    @(posedge Clock); #1;
    Reset = 1'b0;
    r.push_back(mk(16'h0001, 1'b1, T0GO));
    r.push_back(mk(16'h0000, 1'b0, ev(2'd1, 0, 8'h01, 8'h02, 0, 0, 0, 0, 2'b00, 1, 0)));
    r.push_back(mk(16'h0000, 1'b0, IDLE));
    foreach (r[i]) begin
      drive(r[i]);
      @(negedge Clock);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL reset_mid_post[%0d] got=%h want=%h", i, obs, e); end
    end
  endtask

  task automatic test_illegal_logic();
    stim_t t[$];
    logic [26:0] e;
    logic [26:0] ill;
    ill = ev(2'd1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1, 1);
    t.push_back(mk(16'h0188, 1'b1, T0GO));
    t.push_back(mk(16'h0000, 1'b0, ill));
    t.push_back(mk(16'h01C8, 1'b1, T0GO));
    t.push_back(mk(16'h0000, 1'b0, ill));
    t.push_back(mk(16'h0108, 1'b1, T0GO));
`ifdef CTRL_LOGIC_OPS_EN
    t.push_back(mk(16'h0000, 1'b0, ev(2'd1, 0, 8'h00, 8'h02, 0, 0, 1, 0, 2'b00, 0, 0)));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd2, 0, 8'h00, 8'h01, 0, 0, 0, 1, 2'b10, 0, 0)));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd3, 0, 8'h02, 8'h00, 0, 1, 0, 0, 2'b10, 1, 0)));
    t.push_back(mk(16'h0148, 1'b1, T0GO));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd1, 0, 8'h00, 8'h02, 0, 0, 1, 0, 2'b00, 0, 0)));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd2, 0, 8'h00, 8'h01, 0, 0, 0, 1, 2'b11, 0, 0)));
    t.push_back(mk(16'h0000, 1'b0, ev(2'd3, 0, 8'h02, 8'h00, 0, 1, 0, 0, 2'b11, 1, 0)));
`else
    t.push_back(mk(16'h0000, 1'b0, ill));
    t.push_back(mk(16'h0148, 1'b1, T0GO));
    t.push_back(mk(16'h0000, 1'b0, ill));
`endif
    t.push_back(mk(16'h0000, 1'b0, IDLE));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge Clock);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL illegal_logic[%0d] got=%h want=%h", i, obs, e); end
    end
  endtask

  initial begin
    Reset = 1'b1;
    DIN   = 16'h0000;
    Run   = 1'b0;
    test_reset();
    test_mv_mvi();
    test_add_sub();
    test_run_ignore();
    test_reset_mid();
    test_illegal_logic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
